// File: rtl/pipes_sumsquare_seq_if.sv
// pipes_sumsquare_seq_if: vector handshake bundle for pipes_sumsquare_seq.
// MODE exists only when SUMSQ_SUB_MODE_EN is defined.
interface pipes_sumsquare_seq_if #(parameter int LANES = 16, parameter int W = 32);
  logic IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [LANES*W-1:0] vals0, vals1;
  logic [LANES*32-1:0] pipeout;
`ifdef SUMSQ_SUB_MODE_EN
  logic MODE;
  modport master (output IN_VALID, vals0, vals1, MODE, OUT_READY, input IN_READY, OUT_VALID, pipeout);
  modport slave (input IN_VALID, vals0, vals1, MODE, OUT_READY, output IN_READY, OUT_VALID, pipeout);
`else
  modport master (output IN_VALID, vals0, vals1, OUT_READY, input IN_READY, OUT_VALID, pipeout);
  modport slave (input IN_VALID, vals0, vals1, OUT_READY, output IN_READY, OUT_VALID, pipeout);
`endif
endinterface

// File: rtl/pipes_sumsquare_seq.sv
// pipes_sumsquare_seq: 3-stage lane array computing (a+b)^2 as float32;
// SUMSQ_SUB_MODE_EN adds a per-vector MODE selecting (a-b)^2.
module pipes_sumsquare_seq #(
  parameter int LANES = 16,
  parameter int W = 32
) (
  input logic CLK,
  input logic RST,
  input logic EN,
  pipes_sumsquare_seq_if.slave bus
);
  localparam int FW = 2*W+2;
  localparam int PW = $clog2(FW);
  if (W > 63) begin : g_bad_w
    $error("pipes_sumsquare_seq: W=%0d exceeds 63, float exponent would overflow", W);
  end
  logic adv;
  logic v1_q, v2_q, v3_q;
  assign adv = EN & ~RST & (~v3_q | bus.OUT_READY);
  assign bus.IN_READY = adv;
  assign bus.OUT_VALID = v3_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) {v1_q, v2_q, v3_q} <= '0;
    else if (adv) {v1_q, v2_q, v3_q} <= {bus.IN_VALID, v1_q, v2_q};
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [W:0] a, b, s;
    logic [W:0] abs_d, abs_q;
    logic [FW-1:0] sq_d, sq_q;
    logic [FW+23:0] norm;
    logic [PW-1:0] p;
    logic rnd;
    logic [31:0] res_d, res_q;
    assign a = (W+1)'($signed(bus.vals0[(LANES-1-l)*W +: W]));
    assign b = (W+1)'($signed(bus.vals1[(LANES-1-l)*W +: W]));
`ifdef SUMSQ_SUB_MODE_EN
    assign s = bus.MODE ? a - b : a + b;
`else
    assign s = a + b;
`endif
    assign abs_d = s[W] ? -s : s;
    assign sq_d = FW'(abs_q) * FW'(abs_q);
    always_comb begin
      p = '0;
      for (int i = 0; i < FW; i++) if (sq_q[i]) p = PW'(i);
    end
    // leading one lands at the top bit; guard is norm[FW-1], sticky below it
    assign norm = {sq_q, 24'd0} << (PW'(FW-1) - p);
    assign rnd = norm[FW-1] & ((|norm[FW-2:0]) | norm[FW]);
    assign res_d = (sq_q == '0) ? 32'd0 : {1'b0, {8'(p) + 8'd127, norm[FW+22:FW]} + 31'(rnd)};
    always_ff @(posedge CLK or posedge RST)
      if (RST) begin
        abs_q <= '0;
        sq_q <= '0;
        res_q <= '0;
      end else if (adv) begin
        abs_q <= abs_d;
        sq_q <= sq_d;
        res_q <= res_d;
      end
    assign bus.pipeout[(LANES-1-l)*32 +: 32] = res_q;
  end
endmodule

// File: tb/tb_pipes_sumsquare_seq.sv
// tb_pipes_sumsquare_seq: randomized self-checking bench with an arithmetic float32 reference.
module tb_pipes_sumsquare_seq;
  localparam int LANES = 16;
  localparam int W = 32;
  localparam int VW = LANES*32;
  logic CLK = 0, RST = 1, EN = 1;
  int checks = 0, failures = 0;
  logic [VW-1:0] exp_q[$];
  pipes_sumsquare_seq_if #(.LANES(LANES), .W(W)) bus();
  pipes_sumsquare_seq #(.LANES(LANES), .W(W)) dut (.CLK(CLK), .RST(RST), .EN(EN), .bus(bus));
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] f32(logic [127:0] q);
    int p;
    logic [127:0] m, rem, half;
    if (q == 0) return 32'd0;
    p = 0;
    while ((q >> p) > 1) p++;
    if (p <= 23) m = q << (23 - p);
    else begin
      m = q >> (p - 23);
      rem = q - (m << (p - 23));
      half = 128'd1 << (p - 24);
      if (rem > half || (rem == half && m[0])) m++;
      if (m[24]) begin m = m >> 1; p++; end
    end
    return {1'b0, 8'(p + 127), m[22:0]};
  endfunction

  function automatic logic [31:0] lane_res(logic [W-1:0] a, logic [W-1:0] b, logic md);
    longint sa, sb, s;
    logic [127:0] mag;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = md ? sa - sb : sa + sb;
    mag = 128'(s < 0 ? -s : s);
    return f32(mag * mag);
  endfunction

  function automatic logic [VW-1:0] exp_vec(logic [LANES*W-1:0] v0, logic [LANES*W-1:0] v1, logic md);
    logic [VW-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[(LANES-1-l)*32 +: 32] = lane_res(v0[(LANES-1-l)*W +: W], v1[(LANES-1-l)*W +: W], md);
    return r;
  endfunction

  function automatic logic [31:0] lane_of(logic [VW-1:0] v, int l);
    return v[(LANES-1-l)*32 +: 32];
  endfunction

  task automatic set_lane(int l, logic [W-1:0] a, logic [W-1:0] b);
    bus.vals0[(LANES-1-l)*W +: W] = a;
    bus.vals1[(LANES-1-l)*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return $urandom_range(0, 1) ? 32'($urandom_range(0, 3000)) : -32'($urandom_range(0, 3000));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_vec();
    for (int l = 0; l < LANES; l++) set_lane(l, rand_op(), rand_op());
`ifdef SUMSQ_SUB_MODE_EN
    bus.MODE = 1'($urandom_range(0, 1));
`endif
  endtask

  // one clock: sample just before the edge, record accepted vectors after it
  task automatic tick(output logic acc, output logic ret, output logic [VW-1:0] got);
    logic md;
    logic [VW-1:0] e;
    @(negedge CLK);
`ifdef SUMSQ_SUB_MODE_EN
    md = bus.MODE;
`else
    md = 1'b0;
`endif
    acc = bus.IN_VALID & bus.IN_READY;
    ret = bus.OUT_VALID & bus.OUT_READY & EN & ~RST;
    got = bus.pipeout;
    e = exp_vec(bus.vals0, bus.vals1, md);
    @(posedge CLK);
    #1;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #3;
    checks += 3;
    if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", bus.OUT_VALID); end
    if (bus.pipeout !== '0) begin failures++; $display("FAIL reset pipeout got=%h exp=0", bus.pipeout); end
    if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL reset in_ready got=%b exp=0", bus.IN_READY); end
    @(posedge CLK);
    #1 RST = 0;
  endtask

  task automatic test_basic();
    logic acc, ret;
    logic [VW-1:0] got, e;
    logic [31:0] want [4] = '{32'h44524000, 32'h41C80000, 32'h49C8F048, 32'h00000000};
    bus.vals0 = '0;
    bus.vals1 = '0;
    set_lane(0, 32'h11, 32'hC);
    set_lane(1, 32'hFFFFFFEF, 32'hC);
    set_lane(2, 32'h28A, 32'h279);
    set_lane(3, 32'h0, 32'h0);
    bus.OUT_READY = 1;
    bus.IN_VALID = 1;
    for (int c = 0; c < 4; c++) begin
      tick(acc, ret, got);
      if (c == 0) bus.IN_VALID = 0;
      checks++;
      if (ret !== (c == 3)) begin failures++; $display("FAIL basic latency cycle=%0d out_valid got=%b exp=%b", c, ret, c == 3); end
    end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (lane_of(got, l) !== want[l]) begin failures++; $display("FAIL basic lane%0d got=%h exp=%h", l, lane_of(got, l), want[l]); end
    end
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if (got !== e) begin failures++; $display("FAIL basic vector got=%h exp=%h", got, e); end
  endtask

  task automatic test_rounding();
    logic acc, ret, seen;
    logic [VW-1:0] got, e;
    logic [31:0] want [3] = '{32'h5016C04C, 32'h5012B0B0, 32'h5F800000};
    rand_vec();
`ifdef SUMSQ_SUB_MODE_EN
    bus.MODE = 0;
`endif
    set_lane(0, 32'h2AA, 32'h1863C);
    set_lane(1, 32'hFFFFFD56, 32'h1863C);
    set_lane(2, 32'h80000000, 32'h80000000);
    bus.OUT_READY = 1;
    bus.IN_VALID = 1;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick(acc, ret, got);
      bus.IN_VALID = 0;
      seen = ret;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rounding no output got=0 exp=1"); end
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (lane_of(got, l) !== want[l]) begin failures++; $display("FAIL rounding lane%0d got=%h exp=%h", l, lane_of(got, l), want[l]); end
    end
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if (got !== e) begin failures++; $display("FAIL rounding vector got=%h exp=%h", got, e); end
  endtask

  task automatic test_backpressure();
    logic acc, ret;
    logic [VW-1:0] got, e, held;
    int sent = 0, got_n = 0, stall = 0;
    bus.OUT_READY = 1;
    rand_vec();
    for (int c = 0; c < 60 && got_n < 5; c++) begin
      bus.IN_VALID = (sent < 5);
      if (stall > 0 && stall <= 6) begin
        #1;
        if (stall == 1) held = bus.pipeout;
        checks += 3;
        if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL bp in_ready stall=%0d got=%b exp=0", stall, bus.IN_READY); end
        if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL bp out_valid stall=%0d got=%b exp=1", stall, bus.OUT_VALID); end
        if (bus.pipeout !== held) begin failures++; $display("FAIL bp pipeout stall=%0d got=%h exp=%h", stall, bus.pipeout, held); end
        stall++;
        if (stall > 6) bus.OUT_READY = 1;
      end
      tick(acc, ret, got);
      if (acc) begin sent++; rand_vec(); end
      if (ret) begin
        got_n++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got !== e) begin failures++; $display("FAIL bp out%0d got=%h exp=%h", got_n, got, e); end
        if (got_n == 1) begin bus.OUT_READY = 0; stall = 1; end
      end
    end
    bus.IN_VALID = 0;
    checks++;
    if (got_n != 5 || sent != 5) begin failures++; $display("FAIL bp count got=%0d/%0d exp=5/5", got_n, sent); end
  endtask

  task automatic test_enable();
    logic acc, ret, ov;
    logic [VW-1:0] got, e, po;
    int sent = 0, got_n = 0;
    bus.OUT_READY = 1;
    rand_vec();
    for (int c = 0; c < 40 && got_n < 8; c++) begin
      bus.IN_VALID = (sent < 8);
      if (c == 4) begin ov = bus.OUT_VALID; po = bus.pipeout; end
      EN = !(c >= 4 && c < 8);
      if (!EN) begin
        #1;
        checks += 3;
        if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL en in_ready c=%0d got=%b exp=0", c, bus.IN_READY); end
        if (bus.OUT_VALID !== ov) begin failures++; $display("FAIL en out_valid c=%0d got=%b exp=%b", c, bus.OUT_VALID, ov); end
        if (bus.pipeout !== po) begin failures++; $display("FAIL en pipeout c=%0d got=%h exp=%h", c, bus.pipeout, po); end
      end
      tick(acc, ret, got);
      if (acc) begin sent++; rand_vec(); end
      if (ret) begin
        got_n++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got !== e) begin failures++; $display("FAIL en out%0d got=%h exp=%h", got_n, got, e); end
      end
    end
    EN = 1;
    bus.IN_VALID = 0;
    checks++;
    if (got_n != 8) begin failures++; $display("FAIL en count got=%0d exp=8", got_n); end
  endtask

  task automatic test_reset_flight();
    logic acc, ret;
    logic [VW-1:0] got, e;
    int n = 0;
    bus.OUT_READY = 0;
    bus.IN_VALID = 1;
    rand_vec();
    tick(acc, ret, got);
    rand_vec();
    tick(acc, ret, got);
    bus.IN_VALID = 0;
    tick(acc, ret, got);
    checks++;
    if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL rstf preload out_valid got=%b exp=1", bus.OUT_VALID); end
    #2 RST = 1;
    #1;
    checks += 3;
    if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL rstf out_valid got=%b exp=0", bus.OUT_VALID); end
    if (bus.pipeout !== '0) begin failures++; $display("FAIL rstf pipeout got=%h exp=0", bus.pipeout); end
    if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL rstf in_ready got=%b exp=0", bus.IN_READY); end
    exp_q.delete();
    @(posedge CLK);
    #1 RST = 0;
    bus.OUT_READY = 1;
    rand_vec();
    bus.IN_VALID = 1;
    for (int c = 0; c < 10; c++) begin
      tick(acc, ret, got);
      if (c == 0) bus.IN_VALID = 0;
      checks++;
      if (ret !== (c == 3)) begin failures++; $display("FAIL rstf latency cycle=%0d got=%b exp=%b", c, ret, c == 3); end
      if (ret) begin
        n++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got !== e) begin failures++; $display("FAIL rstf vector got=%h exp=%h", got, e); end
      end
    end
    checks++;
    if (n != 1) begin failures++; $display("FAIL rstf outputs got=%0d exp=1", n); end
  endtask

`ifdef SUMSQ_SUB_MODE_EN
  task automatic test_mode();
    logic acc, ret;
    logic [VW-1:0] got, e;
    logic [VW-1:0] outs[$];
    bus.OUT_READY = 1;
    rand_vec();
    set_lane(0, 32'h28A, 32'h279);
    set_lane(1, 32'h80000000, 32'h80000000);
    bus.MODE = 1;
    bus.IN_VALID = 1;
    tick(acc, ret, got);
    bus.MODE = 0;
    tick(acc, ret, got);
    bus.IN_VALID = 0;
    for (int c = 0; c < 8 && outs.size() < 2; c++) begin
      tick(acc, ret, got);
      if (ret) begin
        outs.push_back(got);
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got !== e) begin failures++; $display("FAIL mode vector got=%h exp=%h", got, e); end
      end
    end
    checks++;
    if (outs.size() != 2) begin failures++; $display("FAIL mode outputs got=%0d exp=2", outs.size()); end
    else begin
      checks += 4;
      if (lane_of(outs[0], 0) !== 32'h43908000) begin failures++; $display("FAIL mode sub lane0 got=%h exp=43908000", lane_of(outs[0], 0)); end
      if (lane_of(outs[0], 1) !== 32'h00000000) begin failures++; $display("FAIL mode sub lane1 got=%h exp=0", lane_of(outs[0], 1)); end
      if (lane_of(outs[1], 0) !== 32'h49C8F048) begin failures++; $display("FAIL mode add lane0 got=%h exp=49C8F048", lane_of(outs[1], 0)); end
      if (lane_of(outs[1], 1) !== 32'h5F800000) begin failures++; $display("FAIL mode add lane1 got=%h exp=5F800000", lane_of(outs[1], 1)); end
    end
  endtask
`endif

  task automatic test_random();
    logic acc, ret;
    logic [VW-1:0] got, e;
    for (int c = 0; c < 300; c++) begin
      rand_vec();
      bus.IN_VALID = ($urandom_range(0, 3) != 0);
      bus.OUT_READY = ($urandom_range(0, 2) != 0);
      EN = ($urandom_range(0, 7) != 0);
      #1;
      checks++;
      if (bus.IN_READY !== (EN & (~bus.OUT_VALID | bus.OUT_READY))) begin
        failures++;
        $display("FAIL random in_ready c=%0d got=%b exp=%b", c, bus.IN_READY, EN & (~bus.OUT_VALID | bus.OUT_READY));
      end
      tick(acc, ret, got);
      if (ret) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got !== e) begin failures++; $display("FAIL random out c=%0d got=%h exp=%h", c, got, e); end
      end
    end
    EN = 1;
    bus.IN_VALID = 0;
    bus.OUT_READY = 1;
    for (int c = 0; c < 6; c++) begin
      tick(acc, ret, got);
      if (ret) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got !== e) begin failures++; $display("FAIL random drain got=%h exp=%h", got, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL random leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    bus.IN_VALID = 0;
    bus.OUT_READY = 0;
    bus.vals0 = '0;
    bus.vals1 = '0;
`ifdef SUMSQ_SUB_MODE_EN
    bus.MODE = 0;
`endif
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_enable();
    test_reset_flight();
`ifdef SUMSQ_SUB_MODE_EN
    test_mode();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
